rf_wb_arbiter: RTL

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_arb_pkg.sv | 19 +
 rtl/rf_wb_arbiter_if.sv | 38 +++
 rtl/rf_wb_arbiter_rr_arb2.sv | 46 ++++
 rtl/rf_wb_arbiter.sv | 79 +++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file writeback arbiter: requester IDs,
// address and counter widths, and the saturating counter helper.
package rf_arb_pkg;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

  localparam int unsigned RF_ADDR_W      = 5;
  localparam int unsigned CONFLICT_CNT_W = 16;

  function automatic logic [CONFLICT_CNT_W-1:0] sat_inc(
    input logic [CONFLICT_CNT_W-1:0] v
  );
    return (v == '1) ? v : v + {{(CONFLICT_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request/grant bus and register-file write port of rf_wb_arbiter.
// master = requesters/register file side, slave = the arbiter.
interface rf_wb_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  import rf_arb_pkg::*;

  logic                      alu_valid;
  logic [RF_ADDR_W-1:0]      alu_rd;
  logic [XLEN-1:0]           alu_data;
  logic                      alu_ready;

  logic                      lsu_valid;
  logic [RF_ADDR_W-1:0]      lsu_rd;
  logic [XLEN-1:0]           lsu_data;
  logic                      lsu_ready;

  logic                      wb_we;
  logic [RF_ADDR_W-1:0]      wb_rd;
  logic [XLEN-1:0]           wb_data;
  logic                      last_gnt;
  logic [CONFLICT_CNT_W-1:0] conflict_cnt;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready,
    input  wb_we, wb_rd, wb_data, last_gnt, conflict_cnt
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready,
    output wb_we, wb_rd, wb_data, last_gnt, conflict_cnt
  );

endinterface

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-requester grant logic (ALU vs LSU). Fixed LSU priority by default;
// define RF_WB_ARB_RR_EN for round robin with a single pointer flop.
module rr_arb2
  import rf_arb_pkg::*;
(
`ifdef RF_WB_ARB_RR_EN
  input  logic clk,
`endif
  input  logic rst_n,
  input  logic i_alu_valid,
  input  logic i_lsu_valid,
  output logic o_alu_gnt,
  output logic o_lsu_gnt
);

  logic w_lsu_win;

`ifdef RF_WB_ARB_RR_EN
  req_id_e r_ptr;

  always_comb begin
    w_lsu_win = i_lsu_valid & (~i_alu_valid | (r_ptr == REQ_LSU));
  end

  // Pointer moves to whichever requester did not win the transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= REQ_LSU;
    end else if (o_alu_gnt) begin
      r_ptr <= REQ_LSU;
    end else if (o_lsu_gnt) begin
      r_ptr <= REQ_ALU;
    end
  end
`else
  always_comb begin
    w_lsu_win = i_lsu_valid;
  end
`endif

  always_comb begin
    o_lsu_gnt = rst_n & w_lsu_win;
    o_alu_gnt = rst_n & i_alu_valid & ~w_lsu_win;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: one registered write per cycle from ALU or LSU,
// x0 filtering and contested-cycle counter. Grant policy selected by RF_WB_ARB_RR_EN.
module rf_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic                clk,
  input logic                rst_n,
  rf_wb_arbiter_if.slave     bus
);

  logic                      w_alu_gnt;
  logic                      w_lsu_gnt;
  logic                      w_xfer;
  logic                      w_contested;
  req_id_e                   w_sel;
  logic [RF_ADDR_W-1:0]      w_rd;
  logic [XLEN-1:0]           w_data;

  logic                      r_wb_we;
  logic [RF_ADDR_W-1:0]      r_wb_rd;
  logic [XLEN-1:0]           r_wb_data;
  req_id_e                   r_last_gnt;
  logic [CONFLICT_CNT_W-1:0] r_conflict_cnt;

  rr_arb2 u_arb (
`ifdef RF_WB_ARB_RR_EN
    .clk         (clk),
`endif
    .rst_n       (rst_n),
    .i_alu_valid (bus.alu_valid),
    .i_lsu_valid (bus.lsu_valid),
    .o_alu_gnt   (w_alu_gnt),
    .o_lsu_gnt   (w_lsu_gnt)
  );

  always_comb begin
    w_xfer      = w_alu_gnt | w_lsu_gnt;
    w_contested = bus.alu_valid & bus.lsu_valid;
    w_sel       = w_lsu_gnt ? REQ_LSU : REQ_ALU;
    w_rd        = w_lsu_gnt ? bus.lsu_rd   : bus.alu_rd;
    w_data      = w_lsu_gnt ? bus.lsu_data : bus.alu_data;
  end

  // x0 writes still complete the handshake and update rd/data/last_gnt; only we is suppressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_we        <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_data      <= '0;
      r_last_gnt     <= REQ_ALU;
      r_conflict_cnt <= '0;
    end else begin
      if (w_xfer) begin
        r_wb_we    <= (w_rd != '0);
        r_wb_rd    <= w_rd;
        r_wb_data  <= w_data;
        r_last_gnt <= w_sel;
      end else begin
        r_wb_we    <= 1'b0;
      end
      if (w_contested) begin
        r_conflict_cnt <= sat_inc(r_conflict_cnt);
      end
    end
  end

  always_comb begin
    bus.alu_ready    = w_alu_gnt;
    bus.lsu_ready    = w_lsu_gnt;
    bus.wb_we        = r_wb_we;
    bus.wb_rd        = r_wb_rd;
    bus.wb_data      = r_wb_data;
    bus.last_gnt     = r_last_gnt;
    bus.conflict_cnt = r_conflict_cnt;
  end

endmodule
